// File: rtl/fmlbrg_lineseq_pkg.sv
// FML bridge line sequencer: shared types and constants.
// State encoding and line/beat geometry.
package fmlbrg_lineseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_WB_DATA = 3'd2,
    ST_RF_REQ  = 3'd3,
    ST_RF_DATA = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int BEAT_W = 2;
  localparam logic [3:0] SEL_ALL = 4'hf;
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    BEAT_W'(LINE_WORDS - 1);

endpackage

// File: rtl/fmlbrg_lineseq.sv
// FML bridge line sequencer: writes back and/or refills one
// 4-word cache line between the data memory and FML.
module fmlbrg_lineseq
  import fmlbrg_lineseq_pkg::*;
#(
  parameter int depth = 11,
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wb,
  input  logic                 cmd_rf,
  input  logic [depth-3:0]     cmd_line,
  input  logic [fml_depth-5:0] cmd_wb_adr,
  input  logic [fml_depth-5:0] cmd_rf_adr,
  output logic                 done,
  output logic                 mem_busy,
  output logic [depth-1:0]     mem_a,
  output logic [3:0]           mem_we,
  output logic [31:0]          mem_di,
  output logic [depth-1:0]     mem_a2,
  input  logic [31:0]          mem_do2,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [3:0]           fml_sel,
  output logic [31:0]          fml_do,
  input  logic [31:0]          fml_di
);

  state_t r_state;
  state_t w_state_nxt;

  logic [BEAT_W-1:0]    r_beat;
  logic [BEAT_W-1:0]    w_beat_nxt;
  logic [BEAT_W-1:0]    w_beat_inc;
  logic                 w_accept;

  logic [depth-3:0]     r_line;
  logic [fml_depth-5:0] r_wb_adr;
  logic [fml_depth-5:0] r_rf_adr;
  logic                 r_rf;

  assign w_beat_inc = r_beat + 1'b1;

  // Refill data flows straight from FML into the memory and
  // writeback data straight from the memory onto FML.
  assign mem_a  = {r_line, r_beat};
  assign mem_di = fml_di;
  assign fml_do = mem_do2;

  // State and beat counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Command registers, loaded only when a command is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_line   <= '0;
      r_wb_adr <= '0;
      r_rf_adr <= '0;
      r_rf     <= 1'b0;
    end else if (w_accept) begin
      r_line   <= cmd_line;
      r_wb_adr <= cmd_wb_adr;
      r_rf_adr <= cmd_rf_adr;
      r_rf     <= cmd_rf;
    end
  end

  // Next-state, beat counter and bus outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_accept    = 1'b0;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    mem_busy    = 1'b0;
    mem_we      = '0;
    fml_stb     = 1'b0;
    fml_we      = 1'b0;
    fml_sel     = '0;
    fml_adr     = {r_rf_adr, 4'h0};
    mem_a2      = {r_line, 2'd0};
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept   = 1'b1;
          w_beat_nxt = '0;
          if (cmd_wb)
            w_state_nxt = ST_WB_REQ;
          else if (cmd_rf)
            w_state_nxt = ST_RF_REQ;
          else
            w_state_nxt = ST_FIN;
        end
      end
      ST_WB_REQ: begin
        fml_stb = 1'b1;
        fml_we  = 1'b1;
        fml_adr = {r_wb_adr, 4'h0};
        if (fml_ack) begin
          w_state_nxt = ST_WB_DATA;
          w_beat_nxt  = '0;
        end
      end
      ST_WB_DATA: begin
        // Address runs one word ahead of the beat to cover
        // the registered-address read latency.
        fml_sel    = SEL_ALL;
        fml_adr    = {r_wb_adr, 4'h0};
        mem_a2     = {r_line, w_beat_inc};
        w_beat_nxt = w_beat_inc;
        if (r_beat == BEAT_LAST)
          w_state_nxt = r_rf ? ST_RF_REQ : ST_FIN;
      end
      ST_RF_REQ: begin
        mem_busy = 1'b1;
        fml_stb  = 1'b1;
        if (fml_ack) begin
          w_state_nxt = ST_RF_DATA;
          w_beat_nxt  = '0;
        end
      end
      ST_RF_DATA: begin
        mem_busy   = 1'b1;
        mem_we     = SEL_ALL;
        w_beat_nxt = w_beat_inc;
        if (r_beat == BEAT_LAST)
          w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
